// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM-to-WB result beat with valid/ready handshake.
interface writeback_stage_if #(
    parameter int XLEN = 32
);
    logic            m_valid;
    logic            m_ready;
    logic            m_regwrite;
    logic            m_is_load;
    logic [2:0]      m_funct3;
    logic [1:0]      m_addr_lo;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_alu_result;
    logic [XLEN-1:0] m_load_data;

    modport master (
        output m_valid, m_regwrite, m_is_load, m_funct3, m_addr_lo, m_rd, m_alu_result, m_load_data,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_regwrite, m_is_load, m_funct3, m_addr_lo, m_rd, m_alu_result, m_load_data,
        output m_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: RV32I WB stage with load extension, registered regfile write port,
// per-register pending-write scoreboard and retired-instruction counter.
module writeback_stage #(
    parameter int XLEN     = 32,
    parameter int SB_CNT_W = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Hold,
    writeback_stage_if.slave    m,
    output logic                RegWrite,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     wdata,
    input  logic                issue_valid,
    input  logic                issue_regwrite,
    input  logic [4:0]          issue_rd,
    output logic                issue_ready,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [XLEN-1:0]     instret,
    output logic                misalign_err,
    output logic                sb_err
);
    logic                regwrite_q, regwrite_d;
    logic                ret_q, ret_d;
    logic                misalign_q, misalign_d;
    logic                sb_err_q, sb_err_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     instret_q, instret_d;
    logic [SB_CNT_W-1:0] cnt_q [32];
    logic [SB_CNT_W-1:0] cnt_d [32];

    logic            acc, ld_err, issue_fire, underflow;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic [XLEN-1:0] ld_val, res;

    assign m.m_ready = !Hold;
    assign acc       = m.m_valid && m.m_ready;

    assign lb = m.m_load_data[{m.m_addr_lo, 3'b000} +: 8];
    assign lh = m.m_addr_lo[1] ? m.m_load_data[31:16] : m.m_load_data[15:0];

    always_comb begin
        ld_val = '0;
        ld_err = m.m_is_load;
        case (m.m_funct3)
            3'b000: begin ld_val = {{(XLEN-8){lb[7]}}, lb};   ld_err = 1'b0; end
            3'b100: begin ld_val = {{(XLEN-8){1'b0}}, lb};    ld_err = 1'b0; end
            3'b001: begin ld_val = {{(XLEN-16){lh[15]}}, lh}; ld_err = m.m_is_load && m.m_addr_lo[0]; end
            3'b101: begin ld_val = {{(XLEN-16){1'b0}}, lh};   ld_err = m.m_is_load && m.m_addr_lo[0]; end
            3'b010: begin ld_val = m.m_load_data;             ld_err = m.m_is_load && |m.m_addr_lo; end
            default: ld_err = m.m_is_load;
        endcase
    end

    assign res = !m.m_is_load ? m.m_alu_result : ld_err ? '0 : ld_val;

    // Errored loads still retire their scoreboard entry so decode never deadlocks.
    assign issue_fire = issue_valid && issue_ready && issue_regwrite && issue_rd != 5'd0;
    assign underflow  = ret_q && cnt_q[rd_q] == '0 && !(issue_fire && issue_rd == rd_q);

    always_comb begin
        regwrite_d = acc && m.m_regwrite && m.m_rd != 5'd0 && !ld_err;
        ret_d      = acc && m.m_regwrite && m.m_rd != 5'd0;
        misalign_d = acc && ld_err;
        rd_d       = acc ? m.m_rd : rd_q;
        wdata_d    = acc ? res : wdata_q;
        instret_d  = instret_q + XLEN'(acc);
        sb_err_d   = sb_err_q || underflow;
    end

    for (genvar g = 0; g < 32; g++) begin : g_sb
        logic inc, dec;
        assign inc = issue_fire && issue_rd == 5'(g);
        assign dec = ret_q && rd_q == 5'(g);
        assign cnt_d[g] = (g == 0)                          ? '0 :
                          (inc && !dec)                     ? cnt_q[g] + 1'b1 :
                          (dec && !inc && cnt_q[g] != '0)   ? cnt_q[g] - 1'b1 :
                                                              cnt_q[g];
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            regwrite_q <= 1'b0;
            ret_q      <= 1'b0;
            misalign_q <= 1'b0;
            sb_err_q   <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            instret_q  <= '0;
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            ret_q      <= ret_d;
            misalign_q <= misalign_d;
            sb_err_q   <= sb_err_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            instret_q  <= instret_d;
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // Conservative: a retire landing this cycle does not free a full counter.
    assign issue_ready  = !(issue_regwrite && issue_rd != 5'd0 && &cnt_q[issue_rd]);
    assign rs1_busy     = rs1 != 5'd0 && cnt_q[rs1] != '0;
    assign rs2_busy     = rs2 != 5'd0 && cnt_q[rs2] != '0;
    assign RegWrite     = regwrite_q;
    assign rd           = rd_q;
    assign wdata        = wdata_q;
    assign instret      = instret_q;
    assign misalign_err = misalign_q;
    assign sb_err       = sb_err_q;
endmodule
